// File: rtl/sort_pkg.sv
// ----------------------------------------------------------------------------
// sort_pkg
// Shared types and helpers for the sort output checker.
//   clog2        : ceiling log2, never below 1, used to size the length fields
//   state_t      : checker FSM states (IDLE, IN_PKT)
//   pkt_status_t : status of one finished packet (length plus error flags)
// ----------------------------------------------------------------------------
package sort_pkg;

    // The packet length inside pkt_status_t is wide enough for any
    // MAX_LENGTH. Modules narrow it to their own ADDR_WIDTH+1 on output.
    localparam int PKT_LEN_W = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    typedef struct packed {
        logic [PKT_LEN_W-1:0] len;
        logic                 err_order;
        logic                 err_frame;
        logic                 err_len;
    } pkt_status_t;

    // Returns at least 1. This keeps the length field wide enough to hold
    // MAX_LENGTH+1 when MAX_LENGTH is 1.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sort_chk_cmp.sv
// ----------------------------------------------------------------------------
// sort_chk_cmp
// Combinational less-than between the current beat and the registered
// previous beat of the packet.
//   DATA_WIDTH : width of both operands
//   SIGNED_CMP : 1 compares as two's complement, 0 compares as unsigned
// Ports:
//   cur_data  in  current beat
//   prev_data in  previous beat (registered by the caller)
//   is_less   out cur_data < prev_data
// ----------------------------------------------------------------------------
module sort_chk_cmp
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic [DATA_WIDTH-1:0] cur_data,
    input  logic [DATA_WIDTH-1:0] prev_data,
    output logic                  is_less
);

    // The signedness is fixed at elaboration, so only one comparator is built.
    generate
        if (SIGNED_CMP) begin : g_signed
            assign is_less = $signed(cur_data) < $signed(prev_data);
        end else begin : g_unsigned
            assign is_less = cur_data < prev_data;
        end
    endgenerate

endmodule

// File: rtl/sort_out_checker.sv
// ----------------------------------------------------------------------------
// sort_out_checker
// Passive monitor on the sort engine output stream. It checks each packet for
// non-decreasing order, sop/eop framing and legal length. It produces one
// status pulse per packet and keeps saturating packet and error counters.
// The stream has no backpressure, and the checker never stalls it.
//
// Optional feature (macro SORT_CHK_SIGNATURE_EN):
//   Adds pkt_sum, the modular sum of all beats of the finished packet.
//
// Ports:
//   src_clock   in   rising-edge clock
//   src_reset_n in   asynchronous active-low reset
//   in_data     in   data beat
//   in_sop      in   first beat of packet (qualified by in_valid)
//   in_eop      in   last beat of packet (qualified by in_valid)
//   in_valid    in   beat valid
//   clear       in   synchronous clear of counters and stray_beat
//   pkt_done    out  one-cycle pulse, packet status valid
//   pkt_len     out  beats in finished packet, saturates at MAX_LENGTH+1
//   err_order   out  packet contained a decreasing step
//   err_frame   out  packet was aborted by a new sop
//   err_len     out  packet exceeded MAX_LENGTH beats
//   stray_beat  out  sticky, valid beat seen outside a packet
//   pkt_sum     out  (SORT_CHK_SIGNATURE_EN only) sum of packet beats
//   pkt_count   out  completed packets, saturating
//   err_count   out  packets with any error, saturating
// ----------------------------------------------------------------------------
module sort_out_checker
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LENGTH = 256,
    parameter bit SIGNED_CMP = 1'b0,
    parameter int CNT_WIDTH  = 16,
    localparam int ADDR_WIDTH = clog2(MAX_LENGTH)
) (
    input  logic                           src_clock,
    input  logic                           src_reset_n,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           in_sop,
    input  logic                           in_eop,
    input  logic                           in_valid,
    input  logic                           clear,
    output logic                           pkt_done,
    output logic [ADDR_WIDTH:0]            pkt_len,
    output logic                           err_order,
    output logic                           err_frame,
    output logic                           err_len,
    output logic                           stray_beat,
`ifdef SORT_CHK_SIGNATURE_EN
    output logic [DATA_WIDTH+ADDR_WIDTH:0] pkt_sum,
`endif
    output logic [CNT_WIDTH-1:0]           pkt_count,
    output logic [CNT_WIDTH-1:0]           err_count
);

    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LENGTH + 1);

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d, len_inc;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic                 order_q, order_d;
    logic                 beat_lt;
    logic                 close_d;
    logic                 stray_set;
    pkt_status_t          close_status;

    logic                 pkt_done_q;
    logic [LEN_W-1:0]     len_out_q;
    logic                 err_order_q, err_frame_q, err_len_q;
    logic                 stray_q;
    logic [CNT_WIDTH-1:0] pkt_count_q, err_count_q;

    sort_chk_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_cmp (
        .cur_data  (in_data),
        .prev_data (prev_q),
        .is_less   (beat_lt)
    );

    // FSM state and in-flight packet bookkeeping. A reset mid-packet simply
    // throws the packet away. No pkt_done is produced for it.
    always_ff @(posedge src_clock or negedge src_reset_n) begin
        if (!src_reset_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            prev_q  <= '0;
            order_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            prev_q  <= prev_d;
            order_q <= order_d;
        end
    end

    // Next-state logic and packet close detection. close_d marks the beat that
    // finishes a packet. close_status carries the status that will be shown
    // on the following cycle with pkt_done.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        prev_d       = prev_q;
        order_d      = order_q;
        close_d      = 1'b0;
        stray_set    = 1'b0;
        close_status = '0;
        len_inc      = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_sop) begin
                        len_d   = LEN_W'(1);
                        prev_d  = in_data;
                        order_d = 1'b0;
                        if (in_eop) begin
                            close_d          = 1'b1;
                            close_status.len = PKT_LEN_W'(1);
                        end else begin
                            state_d = IN_PKT;
                        end
                    end else begin
                        stray_set = 1'b1;
                    end
                end
            end
            IN_PKT: begin
                if (in_valid) begin
                    if (in_sop) begin
                        // The new sop closes the old packet as aborted. The beat
                        // itself opens the next packet. A sop+eop beat here is
                        // not reported as a separate single-beat packet. The
                        // status slot is already taken by the aborted one.
                        close_d                = 1'b1;
                        close_status.len       = PKT_LEN_W'(len_q);
                        close_status.err_order = order_q;
                        close_status.err_frame = 1'b1;
                        len_d                  = LEN_W'(1);
                        prev_d                 = in_data;
                        order_d                = 1'b0;
                        state_d                = in_eop ? IDLE : IN_PKT;
                    end else begin
                        len_d   = len_inc;
                        prev_d  = in_data;
                        order_d = order_q | beat_lt;
                        if (in_eop) begin
                            close_d                = 1'b1;
                            close_status.len       = PKT_LEN_W'(len_inc);
                            close_status.err_order = order_q | beat_lt;
                            state_d                = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        close_status.err_len = (close_status.len > PKT_LEN_W'(MAX_LENGTH));
    end

    // Packet status registers. They update only on a close, so the values
    // hold until the next pkt_done.
    always_ff @(posedge src_clock or negedge src_reset_n) begin
        if (!src_reset_n) begin
            pkt_done_q  <= 1'b0;
            len_out_q   <= '0;
            err_order_q <= 1'b0;
            err_frame_q <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            pkt_done_q <= close_d;
            if (close_d) begin
                len_out_q   <= close_status.len[LEN_W-1:0];
                err_order_q <= close_status.err_order;
                err_frame_q <= close_status.err_frame;
                err_len_q   <= close_status.err_len;
            end
        end
    end

    // Counters and the sticky stray flag. The counters advance while
    // pkt_done is high, so a clear in the same cycle overrides that increment.
    always_ff @(posedge src_clock or negedge src_reset_n) begin
        if (!src_reset_n) begin
            pkt_count_q <= '0;
            err_count_q <= '0;
            stray_q     <= 1'b0;
        end else if (clear) begin
            pkt_count_q <= '0;
            err_count_q <= '0;
            stray_q     <= 1'b0;
        end else begin
            if (stray_set) begin
                stray_q <= 1'b1;
            end
            if (pkt_done_q) begin
                if (pkt_count_q != '1) begin
                    pkt_count_q <= pkt_count_q + 1'b1;
                end
                if ((err_order_q || err_frame_q || err_len_q) && (err_count_q != '1)) begin
                    err_count_q <= err_count_q + 1'b1;
                end
            end
        end
    end

`ifdef SORT_CHK_SIGNATURE_EN
    localparam int SUM_W = DATA_WIDTH + ADDR_WIDTH + 1;

    logic [SUM_W-1:0] sum_q, sum_d, close_sum, data_ext, pkt_sum_q;

    // Running modular sum of the packet in flight. It follows the same close
    // points as the FSM above. The aborting sop beat belongs to the next packet.
    always_comb begin
        sum_d     = sum_q;
        close_sum = '0;
        data_ext  = SUM_W'(in_data);
        case (state_q)
            IDLE: begin
                if (in_valid && in_sop) begin
                    sum_d     = data_ext;
                    close_sum = data_ext;
                end
            end
            IN_PKT: begin
                if (in_valid) begin
                    if (in_sop) begin
                        close_sum = sum_q;
                        sum_d     = data_ext;
                    end else begin
                        sum_d     = sum_q + data_ext;
                        close_sum = sum_q + data_ext;
                    end
                end
            end
            default: begin
                sum_d = '0;
            end
        endcase
    end

    // Sum accumulator and the reported packet sum.
    always_ff @(posedge src_clock or negedge src_reset_n) begin
        if (!src_reset_n) begin
            sum_q     <= '0;
            pkt_sum_q <= '0;
        end else begin
            sum_q <= sum_d;
            if (close_d) begin
                pkt_sum_q <= close_sum;
            end
        end
    end

    assign pkt_sum = pkt_sum_q;
`endif

    assign pkt_done   = pkt_done_q;
    assign pkt_len    = len_out_q;
    assign err_order  = err_order_q;
    assign err_frame  = err_frame_q;
    assign err_len    = err_len_q;
    assign stray_beat = stray_q;
    assign pkt_count  = pkt_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_sort_out_checker.sv
// ----------------------------------------------------------------------------
// tb_sort_out_checker
// Drives one stream into three checker instances:
//   dut_u : default parameters (unsigned compare)
//   dut_s : SIGNED_CMP = 1
//   dut_m : MAX_LENGTH = 4, CNT_WIDTH = 3 (length and counter saturation)
// Each packet's expected status is queued when it is sent. The queue is
// popped and compared whenever the DUTs raise pkt_done.
// ----------------------------------------------------------------------------
module tb_sort_out_checker;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_sop;
    logic        in_eop;
    logic        in_valid;
    logic        clear;

    logic        u_pkt_done, s_pkt_done, m_pkt_done;
    logic [8:0]  u_pkt_len, s_pkt_len;
    logic [2:0]  m_pkt_len;
    logic        u_err_order, s_err_order, m_err_order;
    logic        u_err_frame, s_err_frame, m_err_frame;
    logic        u_err_len, s_err_len, m_err_len;
    logic        u_stray, s_stray, m_stray;
    logic [15:0] u_pkt_count, u_err_count, s_pkt_count, s_err_count;
    logic [2:0]  m_pkt_count, m_err_count;
`ifdef SORT_CHK_SIGNATURE_EN
    logic [24:0] u_pkt_sum, s_pkt_sum;
    logic [18:0] m_pkt_sum;
`endif

    typedef struct {
        int len_full;
        int len_m;
        bit eo_u;
        bit eo_s;
        bit eo_m;
        bit ef;
        bit el_m;
        int sum;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    sort_out_checker dut_u (
        .src_clock   (clk),
        .src_reset_n (rst_n),
        .in_data     (in_data),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .in_valid    (in_valid),
        .clear       (clear),
        .pkt_done    (u_pkt_done),
        .pkt_len     (u_pkt_len),
        .err_order   (u_err_order),
        .err_frame   (u_err_frame),
        .err_len     (u_err_len),
        .stray_beat  (u_stray),
`ifdef SORT_CHK_SIGNATURE_EN
        .pkt_sum     (u_pkt_sum),
`endif
        .pkt_count   (u_pkt_count),
        .err_count   (u_err_count)
    );

    sort_out_checker #(.SIGNED_CMP(1'b1)) dut_s (
        .src_clock   (clk),
        .src_reset_n (rst_n),
        .in_data     (in_data),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .in_valid    (in_valid),
        .clear       (clear),
        .pkt_done    (s_pkt_done),
        .pkt_len     (s_pkt_len),
        .err_order   (s_err_order),
        .err_frame   (s_err_frame),
        .err_len     (s_err_len),
        .stray_beat  (s_stray),
`ifdef SORT_CHK_SIGNATURE_EN
        .pkt_sum     (s_pkt_sum),
`endif
        .pkt_count   (s_pkt_count),
        .err_count   (s_err_count)
    );

    sort_out_checker #(.MAX_LENGTH(4), .CNT_WIDTH(3)) dut_m (
        .src_clock   (clk),
        .src_reset_n (rst_n),
        .in_data     (in_data),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .in_valid    (in_valid),
        .clear       (clear),
        .pkt_done    (m_pkt_done),
        .pkt_len     (m_pkt_len),
        .err_order   (m_err_order),
        .err_frame   (m_err_frame),
        .err_len     (m_err_len),
        .stray_beat  (m_stray),
`ifdef SORT_CHK_SIGNATURE_EN
        .pkt_sum     (m_pkt_sum),
`endif
        .pkt_count   (m_pkt_count),
        .err_count   (m_err_count)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls the sequence below
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required sequence to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard: pop one expectation per pkt_done and compare all instances
    always @(negedge clk) begin
        if (rst_n && u_pkt_done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done: pkt_done=1 with no packet pending");
            end else begin
                cur = sb.pop_front();
                checks++;
                if ({s_pkt_done, m_pkt_done} !== 2'b11) begin
                    errors++;
                    $display("[TB] FAIL done_align: s/m pkt_done=%b required 11", {s_pkt_done, m_pkt_done});
                end
                checks++;
                if (u_pkt_len !== 9'(cur.len_full)) begin
                    errors++;
                    $display("[TB] FAIL u_len: got %0d required %0d", u_pkt_len, cur.len_full);
                end
                checks++;
                if (s_pkt_len !== 9'(cur.len_full)) begin
                    errors++;
                    $display("[TB] FAIL s_len: got %0d required %0d", s_pkt_len, cur.len_full);
                end
                checks++;
                if (m_pkt_len !== 3'(cur.len_m)) begin
                    errors++;
                    $display("[TB] FAIL m_len: got %0d required %0d", m_pkt_len, cur.len_m);
                end
                checks++;
                if ({u_err_order, s_err_order, m_err_order} !== {cur.eo_u, cur.eo_s, cur.eo_m}) begin
                    errors++;
                    $display("[TB] FAIL err_order u/s/m: got %b required %b",
                             {u_err_order, s_err_order, m_err_order}, {cur.eo_u, cur.eo_s, cur.eo_m});
                end
                checks++;
                if ({u_err_frame, s_err_frame, m_err_frame} !== {3{cur.ef}}) begin
                    errors++;
                    $display("[TB] FAIL err_frame u/s/m: got %b required %b",
                             {u_err_frame, s_err_frame, m_err_frame}, {3{cur.ef}});
                end
                checks++;
                if ({u_err_len, s_err_len, m_err_len} !== {1'b0, 1'b0, cur.el_m}) begin
                    errors++;
                    $display("[TB] FAIL err_len u/s/m: got %b required %b",
                             {u_err_len, s_err_len, m_err_len}, {1'b0, 1'b0, cur.el_m});
                end
`ifdef SORT_CHK_SIGNATURE_EN
                checks++;
                if (u_pkt_sum !== 25'(cur.sum)) begin
                    errors++;
                    $display("[TB] FAIL u_sum: got %0d required %0d", u_pkt_sum, cur.sum);
                end
                checks++;
                if (m_pkt_sum !== 19'(cur.sum)) begin
                    errors++;
                    $display("[TB] FAIL m_sum: got %0d required %0d", m_pkt_sum, cur.sum);
                end
`endif
            end
        end
    end

    // Drive one valid beat for a single clock, then return the bus to idle
    task automatic applyStimulus(input logic [15:0] d, input logic s, input logic e);
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_data  = '0;
    endtask

    task automatic push_exp(input int lf, input int lm, input bit eou, input bit eos,
                            input bit eom, input bit ef, input bit elm, input int sum);
        exp_t e;
        e.len_full = lf;
        e.len_m    = lm;
        e.eo_u     = eou;
        e.eo_s     = eos;
        e.eo_m     = eom;
        e.ef       = ef;
        e.el_m     = elm;
        e.sum      = sum;
        sb.push_back(e);
    endtask

    // Let pending pkt_done pulses and counter updates settle, bounded in cycles
    task automatic wait_drain();
        repeat (2) @(posedge clk);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d packets still pending, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({u_pkt_done, u_err_order, u_err_frame, u_err_len, u_stray} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b required 00000",
                     {u_pkt_done, u_err_order, u_err_frame, u_err_len, u_stray});
        end
        checks++;
        if (u_pkt_len !== 9'd0) begin
            errors++;
            $display("[TB] FAIL reset_len: got %0d required 0", u_pkt_len);
        end
        checks++;
        if (u_pkt_count !== 16'd0 || u_err_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_counts: got %0d/%0d required 0/0", u_pkt_count, u_err_count);
        end
    endtask

    task automatic test_clean_packet();
        push_exp(4, 4, 0, 0, 0, 0, 0, 14);
        applyStimulus(16'd1, 1'b1, 1'b0);
        applyStimulus(16'd2, 1'b0, 1'b0);
        // Invalid cycle with junk control and data that must be ignored
        in_sop  = 1'b1;
        in_eop  = 1'b1;
        in_data = 16'd0;
        @(posedge clk);
        #1;
        applyStimulus(16'd2, 1'b0, 1'b0);
        applyStimulus(16'd9, 1'b0, 1'b1);
        checks++;
        if (u_pkt_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clean_done_latency: pkt_done=%b required 1", u_pkt_done);
        end
        wait_drain();
        checks++;
        if (u_pkt_count !== 16'd1 || u_err_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL clean_counts: got %0d/%0d required 1/0", u_pkt_count, u_err_count);
        end
    endtask

    task automatic test_order_error();
        push_exp(3, 3, 1, 1, 1, 0, 0, 15);
        applyStimulus(16'd5, 1'b1, 1'b0);
        applyStimulus(16'd3, 1'b0, 1'b0);
        applyStimulus(16'd7, 1'b0, 1'b1);
        wait_drain();
        checks++;
        if (u_pkt_count !== 16'd2 || u_err_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL order_counts: got %0d/%0d required 2/1", u_pkt_count, u_err_count);
        end
    endtask

    task automatic test_signed_compare();
        push_exp(2, 2, 1, 0, 1, 0, 0, 65536);
        applyStimulus(16'hFFFF, 1'b1, 1'b0);
        applyStimulus(16'h0001, 1'b0, 1'b1);
        wait_drain();
        checks++;
        if (u_err_count !== 16'd2 || s_err_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL signed_counts: u/s err_count %0d/%0d required 2/1", u_err_count, s_err_count);
        end
    endtask

    task automatic test_frame_abort();
        push_exp(3, 3, 0, 0, 0, 1, 0, 60);
        push_exp(2, 2, 0, 0, 0, 0, 0, 90);
        applyStimulus(16'd10, 1'b1, 1'b0);
        applyStimulus(16'd20, 1'b0, 1'b0);
        applyStimulus(16'd30, 1'b0, 1'b0);
        applyStimulus(16'd40, 1'b1, 1'b0);
        applyStimulus(16'd50, 1'b0, 1'b1);
        wait_drain();
        checks++;
        if (u_pkt_count !== 16'd5 || u_err_count !== 16'd3) begin
            errors++;
            $display("[TB] FAIL abort_counts: got %0d/%0d required 5/3", u_pkt_count, u_err_count);
        end
    endtask

    task automatic test_length_and_stray();
        push_exp(6, 5, 0, 0, 0, 0, 1, 21);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(16'(i), i == 1, i == 6);
        end
        wait_drain();
        checks++;
        if (m_pkt_count !== 3'd6 || m_err_count !== 3'd4) begin
            errors++;
            $display("[TB] FAIL length_counts: m got %0d/%0d required 6/4", m_pkt_count, m_err_count);
        end
        checks++;
        if (u_stray !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stray_idle: got %b required 0", u_stray);
        end
        applyStimulus(16'd7, 1'b0, 1'b0);
        checks++;
        if (u_stray !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stray_set: got %b required 1", u_stray);
        end
        wait_drain();
    endtask

    task automatic test_saturation();
        push_exp(1, 1, 0, 0, 0, 0, 0, 3);
        applyStimulus(16'd3, 1'b1, 1'b1);
        wait_drain();
        checks++;
        if (m_pkt_count !== 3'd7) begin
            errors++;
            $display("[TB] FAIL sat_reach: m pkt_count %0d required 7", m_pkt_count);
        end
        push_exp(1, 1, 0, 0, 0, 0, 0, 3);
        applyStimulus(16'd3, 1'b1, 1'b1);
        wait_drain();
        checks++;
        if (m_pkt_count !== 3'd7 || m_err_count !== 3'd4) begin
            errors++;
            $display("[TB] FAIL sat_hold: m got %0d/%0d required 7/4", m_pkt_count, m_err_count);
        end
        checks++;
        if (u_pkt_count !== 16'd8 || u_err_count !== 16'd3) begin
            errors++;
            $display("[TB] FAIL sat_u_counts: got %0d/%0d required 8/3", u_pkt_count, u_err_count);
        end
    endtask

    task automatic test_clear();
        push_exp(1, 1, 0, 0, 0, 0, 0, 5);
        applyStimulus(16'd5, 1'b1, 1'b1);
        // pkt_done is high in this cycle, so clear competes with the increment
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        checks++;
        if (u_pkt_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_pulse_width: pkt_done=%b required 0", u_pkt_done);
        end
        checks++;
        if (u_pkt_count !== 16'd0 || u_err_count !== 16'd0 || m_pkt_count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL clear_counts: u %0d/%0d m %0d required 0/0 0",
                     u_pkt_count, u_err_count, m_pkt_count);
        end
        checks++;
        if (u_stray !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_stray: got %b required 0", u_stray);
        end
        checks++;
        if (u_pkt_len !== 9'd1) begin
            errors++;
            $display("[TB] FAIL clear_keeps_status: pkt_len %0d required 1", u_pkt_len);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_packet();
        applyStimulus(16'd5, 1'b1, 1'b0);
        applyStimulus(16'd6, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (u_pkt_len !== 9'd0 || u_pkt_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_status: len %0d done %b required 0 0", u_pkt_len, u_pkt_done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // The discarded packet must not complete even if an eop-like beat follows
        repeat (3) @(posedge clk);
        #1;
        push_exp(2, 2, 0, 0, 0, 0, 0, 12);
        applyStimulus(16'd4, 1'b1, 1'b0);
        applyStimulus(16'd8, 1'b0, 1'b1);
        wait_drain();
        checks++;
        if (u_pkt_count !== 16'd1 || u_err_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midreset_counts: got %0d/%0d required 1/0", u_pkt_count, u_err_count);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_data  = '0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] starting sequence");
        test_reset();
        test_clean_packet();
        test_order_error();
        test_signed_compare();
        test_frame_abort();
        test_length_and_stray();
        test_saturation();
        test_clear();
        test_reset_mid_packet();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
